// File: rtl/sar_cmp_search.sv
// MSB-first successive-approximation search over an external magnitude comparator; 1..WIDTH+1 cycles start->done, start ignored while busy/DONE.
// Optional build macro SAR_FLAGCHK_EN aborts the search with err=1 on non-one-hot comparator flags.
module sar_cmp_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int              KW    = $clog2(WIDTH);
  localparam logic [KW-1:0]   K_TOP = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] probe_acc;
  logic [KW-1:0]    k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             flag_bad;

`ifdef SAR_FLAGCHK_EN
  logic err_q;

  assign flag_bad = (({1'b0, cmp_g} + {1'b0, cmp_l}) + {1'b0, cmp_e}) != 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if ((state_q == S_PROBE || state_q == S_CHECK) && flag_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign flag_bad = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      k_q      <= K_TOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    trial_d   = trial_q;
    acc_d     = acc_q;
    result_d  = result_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    found_d   = found_q;
    // Equality is handled before this is used, so g here means "keep bit k"; all-zero flags act as l.
    probe_acc = cmp_g ? trial_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PROBE;
          trial_d = ONE << K_TOP;
          acc_d   = '0;
          k_d     = K_TOP;
          busy_d  = 1'b1;
          found_d = 1'b0;
        end
      end

      S_PROBE: begin
        if (flag_bad) begin
          state_d  = S_DONE;
          result_d = acc_q;
          found_d  = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (cmp_e) begin
          state_d  = S_DONE;
          result_d = trial_q;
          found_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          acc_d = probe_acc;
          if (k_q != '0) begin
            k_d     = k_q - KW'(1);
            trial_d = probe_acc | (ONE << (k_q - KW'(1)));
          end else begin
            // Last bit resolved without a hit: verify the accumulated value itself.
            trial_d = probe_acc;
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        state_d  = S_DONE;
        result_d = acc_q;
        found_d  = flag_bad ? 1'b0 : cmp_e;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end

      S_DONE: begin
        trial_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;

endmodule

// File: tb/tb_sar_cmp_search.sv
// Scoreboard bench for sar_cmp_search: stimulus queues expected trials/results, a negedge monitor compares.
module tb_sar_cmp_search;

  typedef struct {
    logic [3:0] res;
    logic       fnd;
    logic       e;
    int         lat;
  } exp_res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] target;
  logic [3:0] trial;
  logic [3:0] result;
  logic       cmp_g, cmp_l, cmp_e;
  logic       busy, done, found, err;
  logic       force_gl;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_trial[$];
  exp_res_t   exp_res[$];

  int       busy_cnt  = 0;
  logic     prev_done = 1'b0;
  logic [3:0] mon_et;
  exp_res_t   mon_r;

  always #5 clk = ~clk;

  // Combinational comparator model, with an optional illegal g&l pair injected on trial 12.
  assign cmp_g = (force_gl && trial == 4'd12) ? 1'b1 : (target > trial);
  assign cmp_l = (force_gl && trial == 4'd12) ? 1'b1 : (target < trial);
  assign cmp_e = (force_gl && trial == 4'd12) ? 1'b0 : (target == trial);

  sar_cmp_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .trial  (trial),
    .cmp_g  (cmp_g),
    .cmp_l  (cmp_l),
    .cmp_e  (cmp_e),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_search(input int n, input logic [3:0] t0, input logic [3:0] t1,
                               input logic [3:0] t2, input logic [3:0] t3, input logic [3:0] t4,
                               input logic [3:0] res, input logic fnd, input logic e);
    logic [3:0] tv[5];
    exp_res_t r;
    tv = '{t0, t1, t2, t3, t4};
    for (int i = 0; i < n; i++) exp_trial.push_back(tv[i]);
    r.res = res;
    r.fnd = fnd;
    r.e   = e;
    r.lat = n;
    exp_res.push_back(r);
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: done timeout, got no done expected done within 40 cycles", name);
  endtask

  task automatic search(input logic [3:0] t, input string name);
    @(negedge clk);
    target = t;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name);
  endtask

  // Monitor: every busy cycle presents a trial, every done presents a result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (exp_trial.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trial: got trial %0d expected no search activity", trial);
        end else begin
          mon_et = exp_trial.pop_front();
          chk("trial", trial, mon_et);
        end
        chk("found_clear_while_busy", found, 0);
        chk("err_clear_while_busy", err, 0);
      end
      if (done) begin
        chk("busy_low_with_done", busy, 0);
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %0d expected no done", result);
        end else begin
          mon_r = exp_res.pop_front();
          chk("result", result, mon_r.res);
          chk("found", found, mon_r.fnd);
          chk("err", err, mon_r.e);
          chk("latency", busy_cnt, mon_r.lat);
        end
        busy_cnt = 0;
      end
      if (prev_done) chk("done_one_cycle", done, 0);
      prev_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    target   = 4'd0;
    force_gl = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trial", trial, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Main searches, including the CHECK path (0) and first-probe hit (8).
    expect_search(4, 4'd8, 4'd12, 4'd10, 4'd9, 4'd0, 4'd9, 1'b1, 1'b0);
    search(4'd9, "t9");
    expect_search(5, 4'd8, 4'd4, 4'd2, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
    search(4'd0, "t0");
    expect_search(1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 1'b1, 1'b0);
    search(4'd8, "t8");
    expect_search(4, 4'd8, 4'd12, 4'd14, 4'd15, 4'd0, 4'd15, 1'b1, 1'b0);
    search(4'd15, "t15");

    // Asynchronous reset after the second probe of a search for 7.
    exp_trial.push_back(4'd8);
    exp_trial.push_back(4'd4);
    @(negedge clk);
    target = 4'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_trial.delete();
    exp_res.delete();
    #1;
    chk("midrst_trial", trial, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_found", found, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_search(4, 4'd8, 4'd4, 4'd6, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0);
    search(4'd5, "t5_after_rst");

    // Start re-pulsed mid-search must not restart, nor start a new search afterwards.
    expect_search(3, 4'd8, 4'd4, 4'd6, 4'd0, 4'd0, 4'd6, 1'b1, 1'b0);
    @(negedge clk);
    target = 4'd6;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("repulse");
    repeat (3) @(negedge clk);
    chk("no_restart_busy", busy, 0);

    // Start held high across done: back-to-back searches separated by one IDLE cycle.
    expect_search(4, 4'd8, 4'd4, 4'd2, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0);
    expect_search(3, 4'd8, 4'd12, 4'd10, 4'd0, 4'd0, 4'd10, 1'b1, 1'b0);
    @(negedge clk);
    target = 4'd3;
    start  = 1'b1;
    wait_done("held_first");
    target = 4'd10;
    @(negedge clk);
    chk("held_idle_gap_busy", busy, 0);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    start = 1'b0;
    wait_done("held_second");

    // Illegal g&l flags on the second probe (trial 12) while searching for 9.
`ifdef SAR_FLAGCHK_EN
    expect_search(2, 4'd8, 4'd12, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0, 1'b1);
`else
    expect_search(5, 4'd8, 4'd12, 4'd14, 4'd13, 4'd12, 4'd12, 1'b0, 1'b0);
`endif
    force_gl = 1'b1;
    search(4'd9, "flagchk");
    force_gl = 1'b0;
    repeat (2) @(negedge clk);
`ifdef SAR_FLAGCHK_EN
    chk("err_held", err, 1);
`else
    chk("err_held", err, 0);
`endif
    expect_search(3, 4'd8, 4'd4, 4'd2, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    search(4'd2, "t2_after_flagchk");
    repeat (2) @(negedge clk);
    chk("err_after_new_search", err, 0);

    chk("trial_queue_empty", exp_trial.size(), 0);
    chk("result_queue_empty", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
